// File: rtl/frame_scan_reader_pkg.sv
// Shared frame geometry, bus widths and payload types for the scan reader,
// the pixel-index counter and the plot path.
package frame_scan_reader_pkg;

    localparam int unsigned FRAME_WIDTH  = 320;
    localparam int unsigned FRAME_HEIGHT = 240;
    localparam int unsigned ADDR_W       = 17;
    localparam int unsigned X_W          = 9;
    localparam int unsigned Y_W          = 8;
    localparam int unsigned COLOR_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } scan_state_t;

    // One pixel beat as it travels through the return FIFO and out.
    typedef struct packed {
        logic [COLOR_W-1:0] color;
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic               last;
    } pix_beat_t;

endpackage

// File: rtl/frame_scan_reader_if.sv
// Framebuffer read port plus the downstream pixel stream.
//   master: the scan reader (drives mem_addr/mem_rd and the out_* beat)
//   slave : memory + consumer side (drives mem_rdata and out_ready)
interface frame_scan_reader_if;
    import frame_scan_reader_pkg::*;

    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_rd;
    logic [COLOR_W-1:0] mem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [X_W-1:0]     out_x;
    logic [Y_W-1:0]     out_y;
    logic [COLOR_W-1:0] out_color;
    logic               out_last;

    modport master (
        output mem_addr, mem_rd, out_valid, out_x, out_y, out_color, out_last,
        input  mem_rdata, out_ready
    );

    modport slave (
        input  mem_addr, mem_rd, out_valid, out_x, out_y, out_color, out_last,
        output mem_rdata, out_ready
    );

endinterface

// File: rtl/scan_fifo2.sv
// scan_fifo2: 2-entry synchronous FIFO for returning pixel beats.
// Fall-through when empty: a beat being pushed into an empty FIFO is
// presented on the head in the same cycle and is not stored if popped.
//   clk, reset   : clock, synchronous active-high reset
//   push         : push_data is valid this cycle
//   push_data    : beat to enqueue
//   pop          : head accepted this cycle (only meaningful when head_valid_c)
//   head_c       : current head beat (zero when nothing is available)
//   head_valid_c : a beat is available (stored or falling through)
//   count        : number of stored entries (0..2)
module scan_fifo2
    import frame_scan_reader_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  pix_beat_t push_data,
    input  logic      pop,
    output pix_beat_t head_c,
    output logic      head_valid_c,
    output logic [1:0] count
);

    logic [1:0] count_q;
    pix_beat_t  entry0_q;
    pix_beat_t  entry1_q;

    assign count = count_q;

    // Head selection: stored entry first, otherwise the beat landing now.
    always_comb begin
        head_c       = '0;
        head_valid_c = (count_q != 2'd0) || push;
        if (count_q != 2'd0) begin
            head_c = entry0_q;
        end else if (push) begin
            head_c = push_data;
        end
    end

    // Storage: entry0 is always the head; entry1 shifts down on pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= 2'd0;
            entry0_q <= '0;
            entry1_q <= '0;
        end else begin
            unique case (count_q)
                2'd0: begin
                    if (push && !pop) begin
                        entry0_q <= push_data;
                        count_q  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        entry0_q <= push_data;
                    end else if (push) begin
                        entry1_q <= push_data;
                        count_q  <= 2'd2;
                    end else if (pop) begin
                        count_q <= 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        entry0_q <= entry1_q;
                        if (push) begin
                            entry1_q <= push_data;
                        end else begin
                            count_q <= 2'd1;
                        end
                    end
                end
                default: begin
                    count_q <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/frame_scan_reader.sv
// frame_scan_reader: sweeps the framebuffer in raster order and streams each
// pixel with its (x, y) to a downstream consumer, absorbing the memory's
// 1-cycle read latency and downstream back-pressure.
//   clk, reset : clock, synchronous active-high reset
//   start      : one-cycle pulse, begins a full-frame scan when idle
//   busy       : high from the cycle after an accepted start through done
//   done       : one-cycle pulse after the final pixel is accepted
//   bus        : framebuffer read port and pixel output stream (master)
module frame_scan_reader
    import frame_scan_reader_pkg::*;
#(
    parameter int unsigned WIDTH  = FRAME_WIDTH,
    parameter int unsigned HEIGHT = FRAME_HEIGHT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    frame_scan_reader_if.master  bus
);

    localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

    scan_state_t        state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [X_W-1:0]     x_q;
    logic [Y_W-1:0]     y_q;
    logic [ADDR_W-1:0]  addr_q;

    // Tag for the read currently in flight.
    logic               inflight_q;
    logic [X_W-1:0]     tag_x_q;
    logic [Y_W-1:0]     tag_y_q;
    logic               tag_last_q;

    logic               issue_c;
    logic               start_ok_c;
    logic               last_pos_c;
    logic               pop_c;
    logic [2:0]         occ_c;

    pix_beat_t          push_beat_c;
    pix_beat_t          head_c;
    logic               head_valid_c;
    logic [1:0]         fifo_count;

    assign last_pos_c = (x_q == X_LAST) && (y_q == Y_LAST);
    assign pop_c      = head_valid_c && bus.out_ready;

    // Pixels held or outstanding once this cycle's accept has happened.
    assign occ_c = 3'(fifo_count) + 3'(inflight_q) - 3'(pop_c);

    assign push_beat_c = '{color: bus.mem_rdata, x: tag_x_q, y: tag_y_q, last: tag_last_q};

    scan_fifo2 u_scan_fifo2 (
        .clk          (clk),
        .reset        (reset),
        .push         (inflight_q),
        .push_data    (push_beat_c),
        .pop          (pop_c),
        .head_c       (head_c),
        .head_valid_c (head_valid_c),
        .count        (fifo_count)
    );

    // Scan sequencing and read issue.
    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        issue_c    = 1'b0;
        start_ok_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // done_q blocks a start landing on the done cycle.
                if (start && !done_q) begin
                    start_ok_c = 1'b1;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (occ_c < 3'd2) begin
                    issue_c = 1'b1;
                    if (last_pos_c) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (occ_c == 3'd0) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE) || done_d;
    end

    // State, busy and done registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Raster issue counters; addr holds at the last pixel instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q        <= '0;
            y_q        <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            tag_x_q    <= '0;
            tag_y_q    <= '0;
            tag_last_q <= 1'b0;
        end else begin
            inflight_q <= issue_c;
            if (start_ok_c) begin
                x_q    <= '0;
                y_q    <= '0;
                addr_q <= '0;
            end else if (issue_c) begin
                tag_x_q    <= x_q;
                tag_y_q    <= y_q;
                tag_last_q <= last_pos_c;
                if (!last_pos_c) begin
                    addr_q <= addr_q + ADDR_W'(1);
                    if (x_q == X_LAST) begin
                        x_q <= '0;
                        y_q <= y_q + Y_W'(1);
                    end else begin
                        x_q <= x_q + X_W'(1);
                    end
                end
            end
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_rd    = issue_c;
    assign bus.out_valid = head_valid_c;
    assign bus.out_x     = head_c.x;
    assign bus.out_y     = head_c.y;
    assign bus.out_color = head_c.color;
    assign bus.out_last  = head_c.last;

endmodule

// File: tb/tb_frame_scan_reader.sv
// Bench for frame_scan_reader at a 4x3 frame; memory returns addr[2:0].
module tb_frame_scan_reader;
    import frame_scan_reader_pkg::*;

    localparam int unsigned W    = 4;
    localparam int unsigned H    = 3;
    localparam int unsigned NPIX = W * H;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy;
    logic done;

    frame_scan_reader_if bus ();

    frame_scan_reader #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read framebuffer model.
    logic [COLOR_W-1:0] mem_q = '0;
    always @(posedge clk) begin
        if (bus.mem_rd) mem_q <= bus.mem_addr[2:0];
    end
    assign bus.mem_rdata = mem_q;

    typedef struct {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] color;
        logic               last;
    } beat_t;

    typedef struct {
        logic              start;
        logic              ready;
        logic              busy;
        logic              done;
        logic              rd;
        logic [ADDR_W-1:0] addr;
        logic              valid;
        logic [X_W-1:0]    x;
        logic [Y_W-1:0]    y;
        logic [COLOR_W-1:0] color;
        logic              last;
    } vec_t;

    vec_t  tbl [16];
    beat_t sb_q [$];

    int    n_checks = 0;
    int    n_pass   = 0;
    int    beats_acc, lasts, dones, reads_issued;
    logic  prev_stall;
    beat_t prev_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] pack(input beat_t b);
        return 32'({b.x, b.y, b.color, b.last});
    endfunction

    task automatic push_frame();
        for (int p = 0; p < int'(NPIX); p++) begin
            beat_t b;
            b.x     = X_W'(p % int'(W));
            b.y     = Y_W'(p / int'(W));
            b.color = COLOR_W'(p);
            b.last  = (p == int'(NPIX) - 1);
            sb_q.push_back(b);
        end
    endtask

    task automatic clear_mon();
        beats_acc    = 0;
        lasts        = 0;
        dones        = 0;
        reads_issued = 0;
        prev_stall   = 1'b0;
        sb_q.delete();
    endtask

    // Per-cycle monitor: scoreboard, stall stability, outstanding limit.
    task automatic monitor();
        beat_t cur;
        beat_t exp_b;
        cur.x     = bus.out_x;
        cur.y     = bus.out_y;
        cur.color = bus.out_color;
        cur.last  = bus.out_last;
        if (prev_stall) check("stall_hold", pack(cur), pack(prev_out));
        if (bus.mem_rd) reads_issued++;
        if (bus.out_valid && bus.out_ready) begin
            beats_acc++;
            if (cur.last) lasts++;
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL extra_beat: got 0x%0h expected none", pack(cur));
            end else begin
                exp_b = sb_q.pop_front();
                check("beat", pack(cur), pack(exp_b));
            end
        end
        if (bus.mem_rd) check("held_le2", 32'((reads_issued - beats_acc) <= 2), 32'(1));
        if (done) dones++;
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_out   = cur;
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  32'(busy), 32'(0));
        check({tag, "_done"},  32'(done), 32'(0));
        check({tag, "_rd"},    32'(bus.mem_rd), 32'(0));
        check({tag, "_addr"},  32'(bus.mem_addr), 32'(0));
        check({tag, "_valid"}, 32'(bus.out_valid), 32'(0));
        check({tag, "_last"},  32'(bus.out_last), 32'(0));
        check({tag, "_x"},     32'(bus.out_x), 32'(0));
        check({tag, "_y"},     32'(bus.out_y), 32'(0));
        check({tag, "_color"}, 32'(bus.out_color), 32'(0));
    endtask

    task automatic frame_tail(input int nframes);
        check("sb_empty", 32'(sb_q.size()), 32'(0));
        check("beat_count", 32'(beats_acc), 32'(nframes * int'(NPIX)));
        check("last_count", 32'(lasts), 32'(nframes));
        check("done_count", 32'(dones), 32'(nframes));
    endtask

    task automatic run_until_done(input int budget, input bit rnd);
        bit got;
        got = 1'b0;
        for (int n = 0; n < budget && !got; n++) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            sample();
            if (done) got = 1'b1;
            tick();
        end
        n_checks++;
        if (got) n_pass++;
        else $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
        bus.out_ready = 1'b1;
    endtask

    // Full-throughput timing table; extra adds ignored starts and a restart.
    task automatic run_table(input bit extra);
        clear_mon();
        for (int t = 0; t < 16; t++) begin
            start = tbl[t].start || (extra && (t == 5 || t == 14 || t == 15));
            bus.out_ready = tbl[t].ready;
            if (tbl[t].start || (extra && t == 15)) push_frame();
            sample();
            check("t_busy",  32'(busy), 32'(tbl[t].busy));
            check("t_done",  32'(done), 32'(tbl[t].done));
            check("t_rd",    32'(bus.mem_rd), 32'(tbl[t].rd));
            if (tbl[t].rd) check("t_addr", 32'(bus.mem_addr), 32'(tbl[t].addr));
            check("t_valid", 32'(bus.out_valid), 32'(tbl[t].valid));
            check("t_last",  32'(bus.out_last), 32'(tbl[t].last));
            if (tbl[t].valid) begin
                check("t_x",     32'(bus.out_x), 32'(tbl[t].x));
                check("t_y",     32'(bus.out_y), 32'(tbl[t].y));
                check("t_color", 32'(bus.out_color), 32'(tbl[t].color));
            end
            tick();
        end
        start = 1'b0;
        if (extra) begin
            sample();
            check("restart_rd",   32'(bus.mem_rd), 32'(1));
            check("restart_addr", 32'(bus.mem_addr), 32'(0));
            check("restart_busy", 32'(busy), 32'(1));
            tick();
            run_until_done(60, 1'b0);
            frame_tail(2);
        end else begin
            frame_tail(1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        // Expected cycle table for a start at t0 with out_ready high.
        for (int t = 0; t < 16; t++) begin
            int p;
            p = t - 2;
            tbl[t].start = (t == 0);
            tbl[t].ready = 1'b1;
            tbl[t].busy  = (t >= 1 && t <= 14);
            tbl[t].done  = (t == 14);
            tbl[t].rd    = (t >= 1 && t <= 12);
            tbl[t].addr  = tbl[t].rd ? ADDR_W'(t - 1) : '0;
            tbl[t].valid = (t >= 2 && t <= 13);
            tbl[t].x     = tbl[t].valid ? X_W'(p % int'(W)) : '0;
            tbl[t].y     = tbl[t].valid ? Y_W'(p / int'(W)) : '0;
            tbl[t].color = tbl[t].valid ? COLOR_W'(p) : '0;
            tbl[t].last  = (t == 13);
        end

        reset = 1'b1;
        start = 1'b0;
        bus.out_ready = 1'b1;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        sample();
        check_reset_outputs("rst");
        tick();
        reset = 1'b0;
        sample();
        tick();

        // Full throughput, then again with ignored starts and a restart.
        run_table(1'b0);
        run_table(1'b1);

        // Back-pressure: out_ready low over t3..t12.
        begin
            bit got;
            got = 1'b0;
            clear_mon();
            for (int t = 0; t < 60 && !got; t++) begin
                start = (t == 0);
                bus.out_ready = !(t >= 3 && t <= 12);
                if (t == 0) push_frame();
                sample();
                if (t == 6) check("bp_rd_stalled", 32'(bus.mem_rd), 32'(0));
                if (t == 8) check("bp_valid_held", 32'(bus.out_valid), 32'(1));
                if (done) got = 1'b1;
                tick();
            end
            start = 1'b0;
            bus.out_ready = 1'b1;
            check("bp_done_seen", 32'(got), 32'(1));
            frame_tail(1);
        end

        // Reset mid-scan at t6.
        clear_mon();
        for (int t = 0; t < 11; t++) begin
            start = (t == 0);
            reset = (t == 6);
            if (t == 0) push_frame();
            sample();
            if (t == 7) check_reset_outputs("mid_rst");
            if (t >= 8) begin
                check("mid_rst_busy",  32'(busy), 32'(0));
                check("mid_rst_valid", 32'(bus.out_valid), 32'(0));
            end
            tick();
        end
        start = 1'b0;
        reset = 1'b0;
        check("mid_rst_no_done", 32'(dones), 32'(0));
        clear_mon();
        start = 1'b1;
        push_frame();
        sample();
        tick();
        start = 1'b0;
        run_until_done(60, 1'b0);
        frame_tail(1);

        // Reset and start together.
        clear_mon();
        reset = 1'b1;
        start = 1'b1;
        sample();
        tick();
        reset = 1'b0;
        start = 1'b0;
        sample();
        check("rs_busy", 32'(busy), 32'(0));
        check("rs_rd",   32'(bus.mem_rd), 32'(0));
        tick();
        sample();
        check("rs_busy2",  32'(busy), 32'(0));
        check("rs_valid2", 32'(bus.out_valid), 32'(0));
        tick();

        // Random back-pressure, back-to-back frames.
        for (int f = 0; f < 200; f++) begin
            clear_mon();
            start = 1'b1;
            bus.out_ready = 1'($urandom_range(0, 1));
            push_frame();
            sample();
            tick();
            start = 1'b0;
            run_until_done(200, 1'b1);
            frame_tail(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
